// File: rtl/seg_scan_display_if.sv
// Handshake/bus bundle for the multi-channel seven-segment scan driver.
// master drives samples and reads the pins; slave is the driver block.
interface seg_scan_display_if #(
    parameter int NUM_WIDTH = 32,
    parameter int NUM_CH    = 2,
    parameter int DIGITS    = 4
);
    logic                        Sample;
    logic [NUM_CH*NUM_WIDTH-1:0] Numbers_in;
    logic                        HexMode;
    logic [6:0]                  out7;
    logic [NUM_CH*DIGITS-1:0]    en_out;
    logic                        Busy;

    modport master (
        output Sample, Numbers_in, HexMode,
        input  out7, en_out, Busy
    );

    modport slave (
        input  Sample, Numbers_in, HexMode,
        output out7, en_out, Busy
    );
endinterface

// File: rtl/seg_scan_display.sv
// Multi-channel 7-seg driver: shift-add-3 BCD conversion plus scan mux.
// Optional macro SEGDISP_LZB_EN enables per-channel leading-zero blanking.
module seg_scan_display #(
    parameter int NUM_WIDTH = 32,
    parameter int NUM_CH    = 2,
    parameter int DIGITS    = 4,
    parameter int DIV_BITS  = 17
) (
    input logic Clk,
    input logic Reset,
    seg_scan_display_if.slave bus
);
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    localparam int ND  = NUM_CH * DIGITS;
    localparam int BW  = DIGITS * 4;
    localparam int CBW = DIGITS * 5;
    localparam int DBW = ND * 5;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW  = (ND > 1) ? $clog2(ND) : 1;
    localparam int KW  = $clog2(NUM_WIDTH + 1);
    localparam logic [63:0] DEC_LIM = pow10(DIGITS);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, DONE} state_t;

    state_t                      state_q;
    logic [NUM_CH*NUM_WIDTH-1:0] num_q;
    logic                        hex_q;
    logic [CW-1:0]               ch_q;
    logic [KW-1:0]               cnt_q;
    logic [NUM_WIDTH-1:0]        val_q;
    logic [BW-1:0]               bcd_q;
    logic                        ovf_q;
    logic                        pend_q;
    logic                        busy_q;
    logic [DBW-1:0]              sbuf_q;
    logic [DBW-1:0]              disp_q;
    logic [DIV_BITS-1:0]         div_q;
    logic [SW-1:0]               slot_q;
    logic [ND-1:0]               en_q;
    logic [6:0]                  seg_q;

    logic [NUM_WIDTH-1:0] sel_d;
    logic [63:0]          sel64_d;
    logic                 ovf_d;
    logic                 last_d;
    logic [BW-1:0]        adj_d;
    logic [BW-1:0]        hexv_d;
    logic [CBW-1:0]       res_d;
    logic [DBW-1:0]       sbuf_d;
    logic [4:0]           cur_d;
    logic                 blank_d;
    logic [6:0]           seg_d;

    assign sel_d   = num_q[int'(ch_q)*NUM_WIDTH +: NUM_WIDTH];
    assign sel64_d = 64'(sel_d);
    assign ovf_d   = hex_q ? ((sel64_d >> BW) != 64'd0)
                           : (sel64_d >= DEC_LIM);
    assign last_d  = (int'(ch_q) == NUM_CH - 1);
    assign hexv_d  = BW'(val_q);

    always_comb begin
        adj_d = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    // Channel result: bit 4 of each digit marks a dash.
    always_comb begin
        res_d = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (ovf_q)      res_d[5*d +: 5] = 5'b10000;
            else if (hex_q) res_d[5*d +: 5] = {1'b0, hexv_d[4*d +: 4]};
            else            res_d[5*d +: 5] = {1'b0, bcd_q[4*d +: 4]};
        end
    end

    always_comb begin
        sbuf_d = sbuf_q;
        sbuf_d[int'(ch_q)*CBW +: CBW] = res_d;
    end

`ifdef SEGDISP_LZB_EN
    int  ch_s;
    int  dg_s;
    logic nz_d;
    always_comb begin
        ch_s = int'(slot_q) / DIGITS;
        dg_s = int'(slot_q) % DIGITS;
        nz_d = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= dg_s && disp_q[(ch_s*DIGITS+k)*5 +: 5] != 5'd0)
                nz_d = 1'b1;
        end
        blank_d = (dg_s != 0) && !nz_d;
    end
`else
    assign blank_d = 1'b0;
`endif

    assign cur_d = disp_q[int'(slot_q)*5 +: 5];
    assign seg_d = blank_d  ? 7'b1111111 :
                   cur_d[4] ? 7'b1111110 : seg7(cur_d[3:0]);

    // The final channel's result is folded into DONE so all channels commit at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            hex_q   <= 1'b0;
            ch_q    <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            sbuf_q  <= '0;
            disp_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Sample) begin
                        num_q   <= bus.Numbers_in;
                        hex_q   <= bus.HexMode;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    val_q <= sel_d;
                    bcd_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= ovf_d;
                    if (hex_q || ovf_d)
                        state_q <= last_d ? DONE : NEXT;
                    else
                        state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= {adj_d[BW-2:0], val_q[NUM_WIDTH-1]};
                    val_q <= val_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == KW'(NUM_WIDTH - 1))
                        state_q <= last_d ? DONE : NEXT;
                end
                NEXT: begin
                    sbuf_q  <= sbuf_d;
                    ch_q    <= ch_q + 1'b1;
                    state_q <= LOAD;
                end
                DONE: begin
                    sbuf_q <= sbuf_d;
                    disp_q <= sbuf_d;
                    ch_q   <= '0;
                    if (pend_q || bus.Sample) begin
                        num_q   <= bus.Numbers_in;
                        hex_q   <= bus.HexMode;
                        pend_q  <= 1'b0;
                        state_q <= LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (bus.Sample && (state_q == LOAD || state_q == SHIFT ||
                               state_q == NEXT))
                pend_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q  <= '0;
            slot_q <= '0;
            en_q   <= '1;
            seg_q  <= 7'h7F;
        end else begin
            div_q <= div_q + 1'b1;
            if (&div_q)
                slot_q <= (slot_q == SW'(ND - 1)) ? '0 : slot_q + 1'b1;
            en_q  <= ~(ND'(1) << slot_q);
            seg_q <= seg_d;
        end
    end

    assign bus.out7   = seg_q;
    assign bus.en_out = en_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a short scan divider.
// Expected glyphs are hand-computed; leading-zero slots follow SEGDISP_LZB_EN.
module tb_seg_scan_display;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int total = 0;
    int bad = 0;
    int n;

`ifdef SEGDISP_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h01;
`endif
    localparam logic [6:0] DASH = 7'h7E;

    seg_scan_display_if #(.NUM_WIDTH(32), .NUM_CH(2), .DIGITS(4)) ifc ();

    seg_scan_display #(
        .NUM_WIDTH(32), .NUM_CH(2), .DIGITS(4), .DIV_BITS(2)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(ifc.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // e holds slot 0 in its top 7 bits down to slot 7 in the bottom 7.
    task automatic scan_check(input string tag, input logic [55:0] e);
        int w;
        logic [7:0] en_exp;
        repeat (2) @(negedge Clk);
        w = 0;
        while (ifc.en_out !== 8'hFE && w < 64) begin
            @(negedge Clk);
            w++;
        end
        chk({tag, "_sync"}, ifc.en_out, 8'hFE);
        for (int s = 0; s < 8; s++) begin
            en_exp = ~(8'd1 << s);
            chk($sformatf("%s_en%0d", tag, s), ifc.en_out, en_exp);
            chk($sformatf("%s_seg%0d", tag, s), ifc.out7, e[(7-s)*7 +: 7]);
            repeat (4) @(negedge Clk);
        end
        chk({tag, "_wrap"}, ifc.en_out, 8'hFE);
    endtask

    task automatic convert(input logic [31:0] c1, input logic [31:0] c0,
                           input logic hex, input int pend_at,
                           input logic [63:0] nxt, output int cnt);
        ifc.Numbers_in = {c1, c0};
        ifc.HexMode    = hex;
        ifc.Sample     = 1'b1;
        @(negedge Clk);
        ifc.Sample = 1'b0;
        cnt = 0;
        while (ifc.Busy === 1'b1 && cnt < 1000) begin
            cnt++;
            if (cnt == pend_at) ifc.Numbers_in = nxt;
            ifc.Sample = (cnt == pend_at);
            @(negedge Clk);
        end
        ifc.Sample = 1'b0;
    endtask

    initial begin
        ifc.Sample     = 1'b0;
        ifc.HexMode    = 1'b0;
        ifc.Numbers_in = '0;

        repeat (3) @(negedge Clk);
        chk("rst_en", ifc.en_out, 8'hFF);
        chk("rst_seg", ifc.out7, 7'h7F);
        chk("rst_busy", ifc.Busy, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("first_en", ifc.en_out, 8'hFE);
        scan_check("zero", {7'h01, LZ, LZ, LZ, 7'h01, LZ, LZ, LZ});

        convert(32'd9999, 32'd1234, 1'b0, 0, 64'd0, n);
        chk("dec_busy", n, 68);
        scan_check("dec", {7'h4C, 7'h06, 7'h12, 7'h4F,
                           7'h04, 7'h04, 7'h04, 7'h04});

        convert(32'd5, 32'd10000, 1'b0, 0, 64'd0, n);
        chk("ovf_busy", n, 36);
        scan_check("ovf", {DASH, DASH, DASH, DASH, 7'h24, LZ, LZ, LZ});

        convert(32'h12, 32'h0000BEEF, 1'b1, 0, 64'd0, n);
        chk("hex_busy", n, 4);
        scan_check("hex", {7'h38, 7'h30, 7'h30, 7'h60,
                           7'h12, 7'h4F, LZ, LZ});

        convert(32'h0000FFFF, 32'h0001BEEF, 1'b1, 0, 64'd0, n);
        chk("hexovf_busy", n, 4);
        scan_check("hexovf", {DASH, DASH, DASH, DASH,
                              7'h38, 7'h38, 7'h38, 7'h38});

        convert(32'd9999, 32'd1234, 1'b0, 10, {32'd7, 32'd42}, n);
        chk("pend_busy", n, 136);
        scan_check("pend", {7'h12, 7'h4C, LZ, LZ, 7'h0F, LZ, LZ, LZ});

        ifc.Numbers_in = {32'd9999, 32'd1234};
        ifc.HexMode    = 1'b0;
        ifc.Sample     = 1'b1;
        @(negedge Clk);
        ifc.Sample = 1'b0;
        repeat (30) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_busy", ifc.Busy, 1'b0);
        chk("abort_en", ifc.en_out, 8'hFF);
        chk("abort_seg", ifc.out7, 7'h7F);
        ifc.Sample = 1'b1;
        @(negedge Clk);
        Reset      = 1'b0;
        ifc.Sample = 1'b0;
        repeat (20) @(negedge Clk);
        chk("abort_idle", ifc.Busy, 1'b0);
        scan_check("abort", {7'h01, LZ, LZ, LZ, 7'h01, LZ, LZ, LZ});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
